// File: rtl/router_pkt_tx.sv
// router_pkt_tx
// Packet source for the input side of the 1x3 router. It accepts one command
// (destination address and payload length), buffers the whole payload, then
// serialises header, payload bytes and an XOR parity byte onto the router
// input. The router's busy back-pressure is obeyed. An idle gap follows
// every packet.
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset
//   cmd_valid  command present          cmd_ready  command handshake ready
//   cmd_addr   destination port 0..2    cmd_len    payload length 1..63
//   pay_valid  payload byte present     pay_ready  payload handshake ready
//   pay_data   payload byte
//   busy       router back-pressure
//   data_out   byte to router data_in   pkt_valid  high on header/payload
//   pkt_done   pulse after parity sent  cmd_err    pulse after illegal cmd
module router_pkt_tx #(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
  input  logic       pay_valid,
  output logic       pay_ready,
  input  logic [7:0] pay_data,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       pkt_done,
  output logic       cmd_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_HEADER  = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_PARITY  = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [1:0]    r_addr;
  logic [5:0]    r_len;
  logic [5:0]    r_wr;
  logic [5:0]    r_rd;
  logic [7:0]    r_par;
  logic [GW-1:0] r_gap;
  logic          r_cmd_ready;
  logic          r_pay_ready;
  logic          r_pkt_done;
  logic          r_cmd_err;
  logic [7:0]    r_buf [0:MAX_LEN-1];

  logic          w_cmd_fire;
  logic          w_cmd_legal;
  logic          w_pay_fire;
  logic          w_xfer;
  logic          w_load_last;
  logic          w_pay_last;
  logic          w_gap_last;
  logic [7:0]    w_header;

  // The ready flags are only ever high in IDLE / LOAD, so the handshakes
  // need no extra state qualification.
  assign w_cmd_fire  = cmd_valid & r_cmd_ready;
  assign w_cmd_legal = (cmd_addr != 2'd3) && (cmd_len != 6'd0);
  assign w_pay_fire  = pay_valid & r_pay_ready;
  assign w_xfer      = ~busy && ((r_state == S_HEADER) || (r_state == S_PAYLOAD) ||
                                 (r_state == S_PARITY));
  assign w_header    = {r_len, r_addr};

  // Counter comparisons are done in 7 bits so len=63 never wraps.
  assign w_load_last = (({1'b0, r_wr} + 7'd1) == {1'b0, r_len});
  assign w_pay_last  = (({1'b0, r_rd} + 7'd1) == {1'b0, r_len});
  assign w_gap_last  = (r_gap == GW'(GAP_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_cmd_fire && w_cmd_legal) w_state_nxt = S_LOAD;
      S_LOAD:    if (w_pay_fire && w_load_last) w_state_nxt = S_HEADER;
      S_HEADER:  if (w_xfer) w_state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (w_xfer && w_pay_last) w_state_nxt = S_PARITY;
      S_PARITY:  if (w_xfer) w_state_nxt = S_GAP;
      S_GAP:     if (w_gap_last) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Ready flags are registered from the next state so they read 0 while
  // reset is asserted, even though the FSM itself rests in IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_pay_ready <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_addr      <= 2'd0;
      r_len       <= 6'd0;
      r_wr        <= 6'd0;
      r_rd        <= 6'd0;
      r_par       <= 8'h00;
      r_gap       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_pay_ready <= (w_state_nxt == S_LOAD);
      r_cmd_err   <= w_cmd_fire & ~w_cmd_legal;
      r_pkt_done  <= (r_state == S_PARITY) & w_xfer;

      if (w_cmd_fire && w_cmd_legal) begin
        r_addr <= cmd_addr;
        r_len  <= cmd_len;
        r_wr   <= 6'd0;
      end else if (w_pay_fire) begin
        r_wr <= r_wr + 6'd1;
      end

      if (w_xfer && (r_state == S_HEADER)) begin
        r_par <= w_header;
        r_rd  <= 6'd0;
      end else if (w_xfer && (r_state == S_PAYLOAD)) begin
        r_par <= r_par ^ r_buf[r_rd];
        r_rd  <= r_rd + 6'd1;
      end

      if (r_state == S_GAP) r_gap <= r_gap + GW'(1);
      else                  r_gap <= '0;
    end
  end

  // Payload storage carries no reset; it is always written before being read.
  always_ff @(posedge clock) begin
    if (w_pay_fire) r_buf[r_wr] <= pay_data;
  end

  always_comb begin
    data_out = 8'h00;
    case (r_state)
      S_HEADER:  data_out = w_header;
      S_PAYLOAD: data_out = r_buf[r_rd];
      S_PARITY:  data_out = r_par;
      default:   data_out = 8'h00;
    endcase
  end

  assign pkt_valid = (r_state == S_HEADER) || (r_state == S_PAYLOAD);
  assign cmd_ready = r_cmd_ready;
  assign pay_ready = r_pay_ready;
  assign pkt_done  = r_pkt_done;
  assign cmd_err   = r_cmd_err;

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet source that drives the input side of the 1x3 router.
- Accepts a command (destination address, payload length), then buffers the full payload internally.
- Serialises the packet onto the router input with the router's framing: header byte, payload bytes, then a parity byte.
- Obeys the router's busy back-pressure. Sits between a test/host data source and the router's data_in/pkt_valid/busy pins.

Parameters:
- MAX_LEN, 63, maximum payload length in bytes; internal buffer depth. The 6-bit length field bounds this.
- GAP_CYCLES, 2, idle cycles with pkt_valid low after the parity byte, before the next header may be driven.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge
- cmd_addr  input  2  destination port, 0..2; 3 is illegal
- cmd_len  input  6  payload length, 1..63; 0 is illegal
- pay_valid  input  1  payload byte present
- pay_ready  output  1  payload byte accepted when pay_valid and pay_ready are both high at a rising edge
- pay_data  input  8  payload byte
- busy  input  1  router back-pressure
- data_out  output  8  byte to router data_in
- pkt_valid  output  1  high during header and payload bytes only
- pkt_done  output  1  one-cycle pulse on parity transfer
- cmd_err  output  1  one-cycle pulse when an illegal command is dropped

Behaviour:
- Transfer rule (router side): a byte transfers on a rising edge where the FSM is in HEADER, PAYLOAD or PARITY and busy==0.
  - While busy==1, data_out and pkt_valid hold their values unchanged.
- Reset values: cmd_ready=0, pay_ready=0, data_out=8'h00, pkt_valid=0, pkt_done=0, cmd_err=0. Internal state on reset:
  - FSM=IDLE
  - buffer pointers, byte counter and parity register = 0
- Reset asserted mid-packet aborts the packet immediately; nothing further is driven.
- FSM states: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - cmd_ready=1.
  - On a legal command, latch addr/len, clear the counter, go to LOAD.
  - On an illegal command (addr==3 or len==0): accept it, pulse cmd_err next cycle, stay in IDLE.
- LOAD:
  - pay_ready=1.
  - Each accepted byte is written to the buffer and the counter increments.
  - When the counter reaches len: pay_ready drops on the following cycle and the FSM goes to HEADER. No extra byte is accepted.
- HEADER:
  - data_out={len,addr}, pkt_valid=1.
  - Parity register is initialised to the header byte on transfer.
  - On transfer, go to PAYLOAD with the read pointer at 0.
- PAYLOAD:
  - data_out=buffer[rd], pkt_valid=1.
  - On each transfer: parity ^= byte, rd increments.
  - After the len-th transfer, go to PARITY.
- PARITY:
  - data_out=parity register (XOR of header and all payload bytes), pkt_valid=0.
  - On transfer, pulse pkt_done for one cycle and go to GAP.
- GAP:
  - data_out=0, pkt_valid=0 for GAP_CYCLES cycles, then IDLE.
  - busy is ignored in GAP.
- cmd_ready=0 and pay_ready=0 in every state other than IDLE and LOAD respectively.
- Simultaneous payload valid and command: in IDLE only the command is considered. In LOAD cmd_ready=0.
- Pipeline latency: first header visible one cycle after the final payload byte is accepted. Total on-wire cycles with busy low: len+2.
- Parity is computed in 8 bits with no carry. The length counter is 6 bits; len=63 must not wrap before completion.

Test Plan:
- addr=1, len=3, payload 0x11,0x22,0x33, busy=0 -> data_out sequence 0x0D, 0x11, 0x22, 0x33 with pkt_valid=1, then 0x0D with pkt_valid=0 and pkt_done pulse; then 2 gap cycles with pkt_valid=0.
- Same packet with busy=1 for 3 cycles while the second payload byte (0x22) is driven -> data_out holds 0x22 and pkt_valid stays 1 for 4 cycles total; parity is still 0x0D.
- cmd_addr=3, cmd_len=5 -> cmd_err one-cycle pulse, pay_ready stays 0, pkt_valid never asserts. Then cmd_len=0 with addr=2 -> same response.
- addr=2, len=63, payload 0x00..0x3E -> header 0xFE, 63 payload bytes in order, parity = 0xFE ^ XOR(0x00..0x3E); exactly 64 cycles with pkt_valid=1.
- Reset asserted after the 2nd payload byte of a len=10 packet -> next cycle all outputs at reset values. A new command after reset transmits correctly from its header.
- Two legal commands back-to-back (addr=0, len=1; addr=2, len=2) -> second cmd_ready not high until GAP completes; second header 0x0A appears no earlier than 2 cycles after the first parity transfer.
